keypad_cursor: RTL and testbench

// - Front end of the calculator: turns five raw push buttons into key events for the calculator FSM.
// - Debounces the buttons, moves a cursor over a 4x6 on-screen keypad, and emits the code of the

---
 rtl/keypad_cursor.sv | 166 ++++++++++++++++
 tb/tb_keypad_cursor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/keypad_cursor.sv
// -----------------------------------------------------------------------------
// keypad_cursor
// Front end of the calculator. Five raw push buttons are synchronized,
// debounced and edge-detected. The four direction buttons move a cursor over a
// 4x6 on-screen keypad. The centre button selects the highlighted key: its code
// appears on val together with a one-cycle strobe on button.
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   btn_up      in   1  raw button, asynchronous, active-high
//   btn_down    in   1  raw button, asynchronous, active-high
//   btn_left    in   1  raw button, asynchronous, active-high
//   btn_right   in   1  raw button, asynchronous, active-high
//   btn_center  in   1  raw button, asynchronous, active-high (select key)
//   val         out  5  code of last selected key ([4]=0 hex digit, [4]=1 command)
//   button      out  1  one-cycle strobe, coincident with a val update
//   cursor_row  out  2  cursor row 0..3
//   cursor_col  out  3  cursor column 0..5
// -----------------------------------------------------------------------------
module keypad_cursor #(
  parameter int DEBOUNCE_CYCLES = 1_000_000  // must be >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [4:0] val,
  output logic       button,
  output logic [1:0] cursor_row,
  output logic [2:0] cursor_col
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Bit positions of the buttons in the packed vectors below.
  localparam int B_UP     = 0;
  localparam int B_DOWN   = 1;
  localparam int B_LEFT   = 2;
  localparam int B_RIGHT  = 3;
  localparam int B_CENTER = 4;

  localparam logic [1:0] ROW_MAX = 2'd3;
  localparam logic [2:0] COL_MAX = 3'd5;

  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync2_q;
  logic [4:0]    stable_q, stable_d;
  logic [4:0]    stable_prev_q;
  logic [4:0]    press_q;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];

  logic [1:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [4:0]    val_q, val_d;
  logic          button_q, button_d;

  assign btn_raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  // Row-major keypad: columns 0..3 are hex digits row*4+col, columns 4/5 are
  // the two command keys of each row.
  function automatic logic [4:0] keymap(input logic [1:0] r, input logic [2:0] c);
    logic [4:0] code;
    code = 5'b0_0000;
    if (c < 3'd4) begin
      code = {1'b0, r, c[1:0]};
    end else begin
      case ({r, c[0]})
        3'b000:  code = 5'b1_0000;  // ADD
        3'b001:  code = 5'b1_0001;  // SUB
        3'b010:  code = 5'b1_0010;  // MUL
        3'b011:  code = 5'b1_0100;  // AND
        3'b100:  code = 5'b1_0101;  // OR
        3'b101:  code = 5'b1_0110;  // CE
        3'b110:  code = 5'b1_0011;  // EXE
        default: code = 5'b1_0111;  // CLR
      endcase
    end
    return code;
  endfunction

  // Debounce: the counter only runs while the synced input disagrees with the
  // stable level; any agreeing cycle throws away the progress made so far.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Cursor moves and key selection act on the registered press pulses.
  // Opposing presses in the same cycle cancel; the centre key samples the
  // cursor before any move that happens on the same edge.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    val_d    = val_q;
    button_d = press_q[B_CENTER];

    if (press_q[B_UP] && !press_q[B_DOWN]) begin
      row_d = (row_q == 2'd0) ? ROW_MAX : row_q - 2'd1;
    end else if (press_q[B_DOWN] && !press_q[B_UP]) begin
      row_d = (row_q == ROW_MAX) ? 2'd0 : row_q + 2'd1;
    end

    if (press_q[B_LEFT] && !press_q[B_RIGHT]) begin
      col_d = (col_q == 3'd0) ? COL_MAX : col_q - 3'd1;
    end else if (press_q[B_RIGHT] && !press_q[B_LEFT]) begin
      col_d = (col_q == COL_MAX) ? 3'd0 : col_q + 3'd1;
    end

    if (press_q[B_CENTER]) begin
      val_d = keymap(row_q, col_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      row_q         <= '0;
      col_q         <= '0;
      val_q         <= '0;
      button_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register see the values
      // from before this edge, which is what keeps the synchronizer two deep.
      sync1_q       <= btn_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      // Rising edge of the stable level only; releases never produce events.
      press_q       <= stable_q & ~stable_prev_q;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      row_q         <= row_d;
      col_q         <= col_d;
      val_q         <= val_d;
      button_q      <= button_d;
    end
  end

  assign val        = val_q;
  assign button     = button_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_keypad_cursor.sv
// -----------------------------------------------------------------------------
// tb_keypad_cursor
// Directed bench for keypad_cursor with DEBOUNCE_CYCLES=4. Inputs change and
// outputs are sampled on the falling clock edge. With a button set at a falling
// edge, the next rising edge is the first sample edge k, so the strobe is seen
// after the 8th rising edge (cycle k+7).
// -----------------------------------------------------------------------------
module tb_keypad_cursor;

  localparam int DB = 4;

  localparam logic [4:0] M_UP     = 5'b00001;
  localparam logic [4:0] M_DOWN   = 5'b00010;
  localparam logic [4:0] M_LEFT   = 5'b00100;
  localparam logic [4:0] M_RIGHT  = 5'b01000;
  localparam logic [4:0] M_CENTER = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic [4:0] val;
  logic       button;
  logic [1:0] cursor_row;
  logic [2:0] cursor_col;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_cursor #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .val        (val),
    .button     (button),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {btn_center, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  // Hold a button set, release, and wait long enough for the release to settle.
  task automatic press(input logic [4:0] m, input int hold = 10);
    drive(m);
    tick(hold);
    drive(5'b0);
    tick(8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  // Check the strobe after each of n edges; it must be high only after edge hit.
  task automatic watch_button(input string tag, input int n, input int hit);
    for (int i = 1; i <= n; i++) begin
      tick();
      check(tag, {7'd0, button}, {7'd0, (i == hit)});
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(5'b0);
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_val",    {3'd0, val},        8'h00);
    check("rst_button", {7'd0, button},     8'h00);
    check("rst_row",    {6'd0, cursor_row}, 8'h00);
    check("rst_col",    {5'd0, cursor_col}, 8'h00);

    // Held centre: exactly one strobe, 7 cycles after the first sample edge.
    drive(M_CENTER);
    watch_button("center_hold", 10, 8);
    check("center_val", {3'd0, val}, 8'h00);
    drive(5'b0);
    tick(8);

    // Right x5 reaches the last column, centre selects SUB, one more wraps.
    for (int i = 0; i < 5; i++) press(M_RIGHT);
    check("right5_col", {5'd0, cursor_col}, 8'h05);
    press(M_CENTER);
    check("sub_val", {3'd0, val}, 8'h11);
    press(M_RIGHT);
    check("right_wrap_col", {5'd0, cursor_col}, 8'h00);
    check("right_wrap_row", {6'd0, cursor_row}, 8'h00);

    // Up and left wrap from (0,0) to (3,5); centre selects CLR.
    do_reset();
    press(M_UP);
    check("up_wrap_row", {6'd0, cursor_row}, 8'h03);
    press(M_LEFT);
    check("left_wrap_col", {5'd0, cursor_col}, 8'h05);
    press(M_CENTER);
    check("clr_val", {3'd0, val}, 8'h17);

    // Short glitches on down are ignored; a long hold moves exactly one row.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(M_DOWN);
      tick(2);
      drive(5'b0);
      tick(2);
    end
    tick(8);
    check("glitch_row", {6'd0, cursor_row}, 8'h00);
    press(M_DOWN, 20);
    check("down_hold_row", {6'd0, cursor_row}, 8'h01);

    // Opposing vertical presses cancel.
    press(M_UP | M_DOWN);
    check("updown_row", {6'd0, cursor_row}, 8'h01);

    // Vertical and horizontal together both apply: (1,0) -> (2,5).
    press(M_DOWN | M_LEFT);
    check("diag_row", {6'd0, cursor_row}, 8'h02);
    check("diag_col", {5'd0, cursor_col}, 8'h05);

    // Centre+right at (0,0): key selected from the pre-move cursor.
    do_reset();
    press(M_CENTER | M_RIGHT);
    check("cr_val", {3'd0, val},        8'h00);
    check("cr_col", {5'd0, cursor_col}, 8'h01);

    // From (0,1) move to (1,1), select digit 5 to show val tracks the cursor.
    press(M_DOWN);
    press(M_CENTER);
    check("digit5_val", {3'd0, val}, 8'h05);

    // Reset two cycles into a centre debounce discards progress; a held
    // button is debounced afresh and strobes 7 cycles after reset release.
    drive(M_CENTER);
    tick(2);
    rst = 1'b1;
    watch_button("rst_mid", 3, 0);
    check("rst_mid_val", {3'd0, val}, 8'h00);
    rst = 1'b0;
    watch_button("post_rst", 11, 8);
    check("post_rst_val", {3'd0, val}, 8'h00);
    drive(5'b0);
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
